cpu_mem_if: RTL and testbench

Memory/bus interface stage directly downstream of the 6502 `cpu_core` address output and upstream of its data input. It accepts one byte-wide read or write request at a time and decodes the 16-bit address into three regions: on-chip RAM, a 4-byte I/O register window, and an external ROM port with configurable wait states. Each access completes with a one-cycle `rdy` pulse carrying read data. This block replaces the free-running `addr`→`din` path with a request/ready handshake.

---
 rtl/cpu_mem_pkg.sv | 26 ++
 rtl/cpu_io_regs.sv | 75 +++++++
 rtl/cpu_mem_if.sv | 135 +++++++++++++
 tb/tb_cpu_mem_if.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the cpu_mem_if memory/bus interface stage:
// address-region encodings, I/O window offsets, the unmapped read value
// and the request FSM state encodings.
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      REG_RAM      = 2'd0,
      REG_IO       = 2'd1,
      REG_ROM      = 2'd2,
      REG_UNMAPPED = 2'd3
   } region_t;

   // Byte offsets inside the 4-byte I/O window
   localparam logic [1:0] IO_OFS_OUT     = 2'd0;
   localparam logic [1:0] IO_OFS_IN      = 2'd1;
   localparam logic [1:0] IO_OFS_TICK    = 2'd2;
   localparam logic [1:0] IO_OFS_SCRATCH = 2'd3;

   // Value returned by a read that hits no region
   localparam logic [7:0] UNMAPPED_RDATA = 8'hFF;

   // Request FSM states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/cpu_io_regs.sv
// I/O register window of cpu_mem_if: output port, io_in synchroniser,
// scratch register and the optional free-running tick counter
// (present only when CPU_MEM_IF_TICK_EN is defined).
module cpu_io_regs
   import cpu_mem_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       wr,
   input  logic [1:0] ofs,
   input  logic [7:0] wdata,
   input  logic [7:0] io_in,
   output logic [7:0] io_out,
   output logic [7:0] rdata
);

   logic [7:0] scratch;
   logic [7:0] sync1;
   logic [7:0] sync2;
   logic [7:0] tick;

   // Software-writable registers; io_in and tick offsets ignore data writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         io_out  <= 8'h00;
         scratch <= 8'h00;
      end else if (wr) begin
         case (ofs)
            IO_OFS_OUT:     io_out  <= wdata;
            IO_OFS_SCRATCH: scratch <= wdata;
            default:        ;
         endcase
      end
   end

   // Two-flop synchroniser for the asynchronous io_in port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 8'h00;
         sync2 <= 8'h00;
      end else begin
         sync1 <= io_in;
         sync2 <= sync1;
      end
   end

`ifdef CPU_MEM_IF_TICK_EN
   // Free-running tick; a write to its offset clears it and beats the increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick <= 8'h00;
      end else if (wr && (ofs == IO_OFS_TICK)) begin
         tick <= 8'h00;
      end else begin
         tick <= tick + 8'd1;
      end
   end
`else
   assign tick = 8'h00;
`endif

   // Read mux over the current (pre-edge) register values
   always_comb begin
      // NOTE: default assignment first so no path leaves rdata unassigned (no latch).
      rdata = 8'h00;
      case (ofs)
         IO_OFS_OUT:     rdata = io_out;
         IO_OFS_IN:      rdata = sync2;
         IO_OFS_TICK:    rdata = tick;
         IO_OFS_SCRATCH: rdata = scratch;
         default:        rdata = 8'h00;
      endcase
   end

endmodule

// File: rtl/cpu_mem_if.sv
// cpu_mem_if: request/ready memory interface between the 6502 core and its
// memories. Decodes each accepted request into RAM, I/O window, external
// ROM (with ROM_WAIT extra cycles) or unmapped, and completes it with a
// one-cycle rdy pulse. Optional tick counter: define CPU_MEM_IF_TICK_EN.
module cpu_mem_if
   import cpu_mem_pkg::*;
#(
   parameter int          RAM_AW   = 11,
   parameter logic [15:0] IO_BASE  = 16'h8000,
   parameter logic [15:0] ROM_BASE = 16'hF000,
   parameter int          ROM_AW   = 12,
   parameter int          ROM_WAIT = 1
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req,
   input  logic [15:0]       addr,
   input  logic              we,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   output logic              rdy,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   input  logic [7:0]        io_in,
   output logic [7:0]        io_out
);

   localparam int CNT_W = (ROM_WAIT > 0) ? $clog2(ROM_WAIT + 1) : 1;

   logic [0:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [RAM_AW-1:0] addr_q;
   logic              we_q;
   logic [7:0]        wdata_q;
   region_t           region_q;
   region_t           region_in;
   logic              done;
   logic [7:0]        rd_val;
   logic [7:0]        io_rdata;
   logic [1:0]        io_ofs;
   logic              io_wr;
   logic              ram_we;
   logic [7:0]        ram [2**RAM_AW];

   // Region priority: RAM, then I/O window, then ROM, else unmapped
   function automatic region_t decode(input logic [15:0] a);
      if ((a >> RAM_AW) == 16'd0)                   return REG_RAM;
      else if (a >= IO_BASE && a <= IO_BASE + 16'd3) return REG_IO;
      else if (a >= ROM_BASE)                        return REG_ROM;
      else                                           return REG_UNMAPPED;
   endfunction

   assign region_in = decode(addr);
   assign done      = (state == ST_BUSY) && (cnt == '0);
   assign ram_we    = done && we_q && (region_q == REG_RAM);
   assign io_wr     = done && we_q && (region_q == REG_IO);
   assign io_ofs    = addr_q[1:0] - IO_BASE[1:0];

   // Request FSM: accept, count ROM wait states, complete with a rdy pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= 8'h00;
         region_q <= REG_UNMAPPED;
         rom_addr <= '0;
         rdata    <= 8'h00;
         rdy      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         rdy <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A high rdy means the requester is still holding the finished request
               if (req && !rdy) begin
                  addr_q   <= addr[RAM_AW-1:0];
                  we_q     <= we;
                  wdata_q  <= wdata;
                  region_q <= region_in;
                  cnt      <= (region_in == REG_ROM) ? CNT_W'(ROM_WAIT) : '0;
                  if (region_in == REG_ROM) begin
                     rom_addr <= addr[ROM_AW-1:0];
                  end
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state <= ST_IDLE;
                  rdy   <= 1'b1;
                  if (!we_q) begin
                     rdata <= rd_val;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read data source for the access completing this cycle
   always_comb begin
      rd_val = UNMAPPED_RDATA;
      case (region_q)
         REG_RAM: rd_val = ram[addr_q];
         REG_IO:  rd_val = io_rdata;
         REG_ROM: rd_val = rom_data;
         default: rd_val = UNMAPPED_RDATA;
      endcase
   end

   // On-chip RAM write port
   // NOTE: memory contents are deliberately not reset; only control state is.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[addr_q] <= wdata_q;
      end
   end

   cpu_io_regs u_io_regs (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (io_wr),
      .ofs     (io_ofs),
      .wdata   (wdata_q),
      .io_in   (io_in),
      .io_out  (io_out),
      .rdata   (io_rdata)
   );

endmodule

// File: tb/tb_cpu_mem_if.sv
// Self-checking bench for cpu_mem_if: directed accesses to every region,
// a behavioural model of the memory map compared every cycle, and
// hand-computed literal expectations for the key results.
module tb_cpu_mem_if;

   localparam int ROM_WAIT = 2;
`ifdef CPU_MEM_IF_TICK_EN
   localparam bit TICK_EN = 1'b1;
`else
   localparam bit TICK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        we = 1'b0;
   logic [7:0]  wdata = 8'h00;
   logic [7:0]  rom_data = 8'h00;
   logic [7:0]  io_in = 8'h00;
   logic [7:0]  rdata;
   logic        rdy;
   logic [11:0] rom_addr;
   logic [7:0]  io_out;

   cpu_mem_if #(.ROM_WAIT(ROM_WAIT)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .addr     (addr),
      .we       (we),
      .wdata    (wdata),
      .rdata    (rdata),
      .rdy      (rdy),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .io_in    (io_in),
      .io_out   (io_out)
   );

   always #5 clk = ~clk;

   // Edge counter and io_in history (io_hist[n&3] = io_in sampled at edge n)
   int         cyc = 0;
   logic [7:0] io_hist [4] = '{default: 8'h00};
   always @(posedge clk) begin
      io_hist[(cyc + 1) & 3] = io_in;
      cyc = cyc + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  ram_m [2048];
   logic [7:0]  m_io_out = 8'h00;
   logic [7:0]  m_scratch = 8'h00;
   logic [7:0]  m_rdata = 8'h00;
   logic [11:0] m_rom_addr = 12'h000;
   int          tick_z = 0;
   bit          run = 1'b0;

   // Outstanding request: address, kind, acceptance edge, completion edge
   logic [15:0] p_addr = 16'h0;
   bit          p_we = 1'b0;
   logic [7:0]  p_wdata = 8'h0;
   int          p_acc = -1;
   int          p_done = -1;
   bit          p_valid = 1'b0;

   // 0 = RAM, 1 = I/O, 2 = ROM, 3 = unmapped
   function automatic int region_of(input logic [15:0] a);
      if (a < 16'h0800)                      return 0;
      if (a >= 16'h8000 && a <= 16'h8003)    return 1;
      if (a >= 16'hF000)                     return 2;
      return 3;
   endfunction

   function automatic int wait_of(input logic [15:0] a);
      return (region_of(a) == 2) ? ROM_WAIT : 0;
   endfunction

   // Tick read at completion edge c returns the count after edge c-1
   function automatic logic [7:0] tick_val(input int c);
      return TICK_EN ? 8'(c - 1 - tick_z) : 8'h00;
   endfunction

   // Apply the completing access (edge c) to the model
   task automatic model_complete(input int c);
      case (region_of(p_addr))
         0: if (p_we) ram_m[p_addr[10:0]] = p_wdata;
            else      m_rdata = ram_m[p_addr[10:0]];
         1: begin
            if (p_we) begin
               case (p_addr[1:0])
                  2'd0: m_io_out = p_wdata;
                  2'd2: if (TICK_EN) tick_z = c;
                  2'd3: m_scratch = p_wdata;
                  default: ;
               endcase
            end else begin
               case (p_addr[1:0])
                  2'd0: m_rdata = m_io_out;
                  2'd1: m_rdata = io_hist[(c - 2) & 3];
                  2'd2: m_rdata = tick_val(c);
                  default: m_rdata = m_scratch;
               endcase
            end
         end
         2: if (!p_we) m_rdata = rom_data;
         default: if (!p_we) m_rdata = 8'hFF;
      endcase
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      bit exp_rdy;
      if (run && reset_n) begin
         if (p_valid && cyc == p_acc && region_of(p_addr) == 2) m_rom_addr = p_addr[11:0];
         exp_rdy = p_valid && (cyc == p_done);
         if (exp_rdy) model_complete(cyc);
         check("rdy", {15'd0, rdy}, {15'd0, exp_rdy});
         check("rdata", {8'd0, rdata}, {8'd0, m_rdata});
         check("io_out", {8'd0, io_out}, {8'd0, m_io_out});
         check("rom_addr", {4'd0, rom_addr}, {4'd0, m_rom_addr});
      end
   end

   // ---------------- stimulus ----------------
   task automatic start_req(input logic [15:0] a, input bit w, input logic [7:0] d);
      @(negedge clk);
      req = 1'b1; addr = a; we = w; wdata = d;
      p_addr = a; p_we = w; p_wdata = d;
      p_acc = cyc + 1;
      p_done = cyc + 2 + wait_of(a);
      p_valid = 1'b1;
   endtask

   task automatic access(input logic [15:0] a, input bit w, input logic [7:0] d);
      bit got;
      got = 1'b0;
      start_req(a, w, d);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (rdy) got = 1'b1;
      end
      if (!got) check("rdy_timeout", 16'd0, 16'd1);
      req = 1'b0;
   endtask

   // Assert reset just after an edge, hold for two edges, release just after an edge
   task automatic do_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      req = 1'b0;
      p_valid = 1'b0;
      m_rdata = 8'h00; m_io_out = 8'h00; m_scratch = 8'h00; m_rom_addr = 12'h000;
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      tick_z = cyc;
   endtask

   initial begin
      do_reset();
      run = 1'b1;
      check("reset_rdy", {15'd0, rdy}, 16'd0);
      check("reset_rdata", {8'd0, rdata}, 16'h00);
      check("reset_io_out", {8'd0, io_out}, 16'h00);
      check("reset_rom_addr", {4'd0, rom_addr}, 16'h000);

      // Tick right after reset: completes two edges after release, then 3 later
      access(16'h8002, 1'b0, 8'h00);
      check("tick_after_reset", {8'd0, rdata}, TICK_EN ? 16'h01 : 16'h00);
      access(16'h8002, 1'b0, 8'h00);
      check("tick_increasing", {8'd0, rdata}, TICK_EN ? 16'h04 : 16'h00);

      // RAM write then read back
      access(16'h0123, 1'b1, 8'h5A);
      access(16'h0123, 1'b0, 8'h00);
      check("ram_read", {8'd0, rdata}, 16'h5A);

      // ROM read with wait states, then an ignored ROM write
      rom_data = 8'hA9;
      access(16'hF010, 1'b0, 8'h00);
      check("rom_read", {8'd0, rdata}, 16'hA9);
      check("rom_addr", {4'd0, rom_addr}, 16'h010);
      access(16'hF010, 1'b1, 8'h11);
      check("rom_write_no_effect", {8'd0, rdata}, 16'hA9);

      // I/O window
      access(16'h8000, 1'b1, 8'h3C);
      check("io_out_write", {8'd0, io_out}, 16'h3C);
      io_in = 8'h81;
      repeat (3) @(negedge clk);
      access(16'h8001, 1'b0, 8'h00);
      check("io_in_read", {8'd0, rdata}, 16'h81);
      access(16'h8001, 1'b1, 8'h00);
      access(16'h8001, 1'b0, 8'h00);
      check("io_in_write_ignored", {8'd0, rdata}, 16'h81);
      access(16'h8003, 1'b1, 8'hC5);
      access(16'h8003, 1'b0, 8'h00);
      check("scratch_read", {8'd0, rdata}, 16'hC5);
      access(16'h8000, 1'b0, 8'h00);
      check("io_out_read", {8'd0, rdata}, 16'h3C);
      access(16'h8002, 1'b1, 8'h00);
      repeat (8) @(negedge clk);
      access(16'h8002, 1'b0, 8'h00);
      check("tick_after_clear", {8'd0, rdata}, TICK_EN ? 16'h0A : 16'h00);

      // Unmapped and region boundaries
      access(16'h4000, 1'b0, 8'h00);
      check("unmapped_read", {8'd0, rdata}, 16'hFF);
      access(16'h07FF, 1'b1, 8'h42);
      access(16'h4000, 1'b1, 8'h99);
      access(16'h07FF, 1'b0, 8'h00);
      check("ram_top", {8'd0, rdata}, 16'h42);
      access(16'h0800, 1'b0, 8'h00);
      check("ram_end_unmapped", {8'd0, rdata}, 16'hFF);
      access(16'h8004, 1'b0, 8'h00);
      check("io_end_unmapped", {8'd0, rdata}, 16'hFF);
      rom_data = 8'h6C;
      access(16'hFFFF, 1'b0, 8'h00);
      check("rom_top", {8'd0, rdata}, 16'h6C);
      check("rom_top_addr", {4'd0, rom_addr}, 16'hFFF);

      // Reset pulse clears outputs and registers
      do_reset();
      check("pulse_rdy", {15'd0, rdy}, 16'd0);
      check("pulse_rdata", {8'd0, rdata}, 16'h00);
      check("pulse_io_out", {8'd0, io_out}, 16'h00);
      access(16'h8003, 1'b0, 8'h00);
      check("pulse_scratch", {8'd0, rdata}, 16'h00);

      // Reset during accesses: ROM read in its wait states, RAM write before completion
      access(16'h0010, 1'b1, 8'h77);
      start_req(16'hF020, 1'b0, 8'h00);
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_rom_no_rdy", {15'd0, rdy}, 16'd0);
      end
      start_req(16'h0010, 1'b1, 8'hEE);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_ram_no_rdy", {15'd0, rdy}, 16'd0);
      end
      access(16'h0010, 1'b0, 8'h00);
      check("abort_ram_unchanged", {8'd0, rdata}, 16'h77);

      repeat (3) @(negedge clk);
      run = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound so the bench always terminates
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
